// File: rtl/game_sequencer.sv
// game_sequencer: target-game round controller tracking score, lives, round time and GET hold.
module game_sequencer #(
    parameter logic [5:0] TIME_INIT  = 6'd60,
    parameter logic [1:0] LIVES_INIT = 2'd3,
    parameter logic [2:0] GET_HOLD   = 3'd2,
    parameter logic [7:0] MATCH_PTS  = 8'd2,
    parameter logic [7:0] HIT_PTS    = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       sec_tick,
    input  logic       hit,
    input  logic [2:0] hit_group,
    input  logic       miss,
    input  logic [2:0] selected_group,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [5:0] time_left,
    output logic       get_pulse
);
    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_GET   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t     cur, nxt;
    logic [7:0] score_n;
    logic [1:0] lives_n;
    logic [5:0] time_n;
    logic [2:0] hold_cnt, hold_n;
    logic       pulse_n;
    logic       active, expire, dead, match, hold_done;
    logic [8:0] sum;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= S_RESET;
            score     <= 8'd0;
            lives     <= LIVES_INIT;
            time_left <= TIME_INIT;
            hold_cnt  <= 3'd0;
            get_pulse <= 1'b0;
        end else begin
            cur       <= nxt;
            score     <= score_n;
            lives     <= lives_n;
            time_left <= time_n;
            hold_cnt  <= hold_n;
            get_pulse <= pulse_n;
        end
    end

    // Priority: game-over conditions, then miss, then hit (a hit coinciding with a miss is dropped).
    always_comb begin
        nxt       = cur;
        score_n   = score;
        lives_n   = lives;
        time_n    = time_left;
        hold_n    = hold_cnt;
        pulse_n   = 1'b0;
        active    = cur == S_START || cur == S_GET;
        expire    = active && sec_tick && time_left <= 6'd1;
        dead      = active && miss && lives <= 2'd1;
        match     = hit_group == selected_group;
        sum       = {1'b0, score} + {1'b0, match ? MATCH_PTS : HIT_PTS};
        hold_done = sec_tick && ({1'b0, hold_cnt} + 4'd1 >= {1'b0, GET_HOLD});
        case (cur)
            S_RESET: begin
                score_n = 8'd0;
                lives_n = LIVES_INIT;
                time_n  = TIME_INIT;
                hold_n  = 3'd0;
                nxt     = S_WAIT;
            end
            S_WAIT:  nxt = btn_start ? S_START : S_WAIT;
            S_START, S_GET: begin
                if (sec_tick)
                    time_n = expire ? 6'd0 : time_left - 6'd1;
                if (miss)
                    lives_n = dead ? 2'd0 : lives - 2'd1;
                if (expire || dead)
                    nxt = S_OVER;
                else if (cur == S_GET) begin
                    if (hold_done) begin
                        hold_n = 3'd0;
                        nxt    = S_START;
                    end else if (sec_tick)
                        hold_n = hold_cnt + 3'd1;
                end else if (hit && !miss) begin
                    score_n = sum[8] ? 8'hFF : sum[7:0];
                    nxt     = match ? S_GET : S_START;
                    pulse_n = match;
                end
            end
            S_OVER:  nxt = btn_start ? S_RESET : S_OVER;
            default: nxt = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and random stimulus checked against a rule-level game model.
module tb_game_sequencer;
    logic       clk = 1'b0;
    logic       reset, btn_start, sec_tick, hit, miss;
    logic [2:0] hit_group, selected_group;
    logic [2:0] state;
    logic [7:0] score;
    logic [1:0] lives;
    logic [5:0] time_left;
    logic       get_pulse;

    int checks = 0;
    int passes = 0;
    int m_state, m_score, m_lives, m_time, m_hold, m_pulse;

    game_sequencer dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .sec_tick(sec_tick),
        .hit(hit), .hit_group(hit_group), .miss(miss), .selected_group(selected_group),
        .state(state), .score(score), .lives(lives), .time_left(time_left),
        .get_pulse(get_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Game rules as stated: round timer, lives, score saturating at 255, GET held for 2 ticks.
    task automatic model_step();
        int over;
        int matched;
        m_pulse = 0;
        if (reset) begin
            m_state = 0; m_score = 0; m_lives = 3; m_time = 60; m_hold = 0;
        end else if (m_state == 0) begin
            m_score = 0; m_lives = 3; m_time = 60; m_hold = 0; m_state = 1;
        end else if (m_state == 1) begin
            if (btn_start) m_state = 2;
        end else if (m_state == 2 || m_state == 3) begin
            over = int'((sec_tick && m_time <= 1) || (miss && m_lives <= 1));
            matched = int'(hit_group == selected_group);
            if (sec_tick) m_time = (m_time > 1) ? m_time - 1 : 0;
            if (miss) m_lives = m_lives - 1;
            if (over != 0) m_state = 4;
            else if (m_state == 3) begin
                if (sec_tick) begin
                    m_hold++;
                    if (m_hold >= 2) begin
                        m_hold = 0;
                        m_state = 2;
                    end
                end
            end else if (hit && !miss) begin
                m_score = m_score + ((matched != 0) ? 2 : 1);
                if (m_score > 255) m_score = 255;
                if (matched != 0) begin
                    m_state = 3;
                    m_pulse = 1;
                end
            end
        end else if (m_state == 4) begin
            if (btn_start) m_state = 0;
        end else m_state = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("score", 32'(score), 32'(m_score));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("time_left", 32'(time_left), 32'(m_time));
        chk("get_pulse", 32'(get_pulse), 32'(m_pulse));
    endtask

    task automatic step(input logic b, input logic s, input logic h, input logic [2:0] g, input logic m);
        btn_start = b; sec_tick = s; hit = h; hit_group = g; miss = m;
        tick();
        btn_start = 0; sec_tick = 0; hit = 0; miss = 0;
    endtask

    initial begin
        reset = 1; btn_start = 0; sec_tick = 0; hit = 0; miss = 0;
        hit_group = 0; selected_group = 3'd5;
        m_state = 0; m_score = 0; m_lives = 3; m_time = 60; m_hold = 0; m_pulse = 0;
        #2;
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_time", 32'(time_left), 60);
        reset = 0;
        step(0, 0, 0, 0, 0);
        chk("wait_state", 32'(state), 1);
        step(1, 0, 0, 0, 0);
        chk("start_state", 32'(state), 2);
        chk("start_score", 32'(score), 0);
        step(0, 0, 1, 3'd5, 0);
        chk("match_state", 32'(state), 3);
        chk("match_score", 32'(score), 2);
        chk("match_pulse", 32'(get_pulse), 1);
        step(0, 0, 1, 3'd5, 0);
        chk("pulse_one_cycle", 32'(get_pulse), 0);
        chk("get_ignores_hit", 32'(score), 2);
        step(0, 1, 0, 0, 0);
        chk("hold_one", 32'(state), 3);
        step(0, 1, 0, 0, 0);
        chk("hold_back_start", 32'(state), 2);
        chk("hold_time", 32'(time_left), 58);
        step(0, 0, 1, 3'd1, 0);
        chk("nonmatch_score", 32'(score), 3);
        chk("nonmatch_state", 32'(state), 2);
        for (int i = 0; i < 251; i++) step(0, 0, 1, 3'd1, 0);
        chk("score_254", 32'(score), 254);
        step(0, 0, 1, 3'd5, 0);
        chk("score_sat", 32'(score), 255);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("back_start", 32'(state), 2);
        step(0, 0, 1, 3'd5, 1);
        chk("miss_drops_hit", 32'(score), 255);
        chk("miss_lives2", 32'(lives), 2);
        step(0, 0, 0, 0, 1);
        chk("miss_lives1", 32'(lives), 1);
        step(0, 0, 0, 0, 1);
        chk("miss_lives0", 32'(lives), 0);
        chk("miss_over", 32'(state), 4);
        step(0, 1, 1, 3'd5, 1);
        chk("over_frozen", 32'(score), 255);
        step(1, 0, 0, 0, 0);
        chk("over_to_reset", 32'(state), 0);
        step(0, 0, 0, 0, 0);
        chk("reset_to_wait", 32'(state), 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0);
        chk("time_one", 32'(time_left), 1);
        step(0, 1, 1, 3'd5, 0);
        chk("expire_over", 32'(state), 4);
        chk("expire_time", 32'(time_left), 0);
        chk("expire_score", 32'(score), 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 3'd5, 0);
        step(0, 1, 0, 0, 0);
        chk("mid_get", 32'(state), 3);
        reset = 1;
        step(0, 0, 0, 0, 0);
        chk("get_reset_state", 32'(state), 0);
        chk("get_reset_score", 32'(score), 0);
        chk("get_reset_time", 32'(time_left), 60);
        chk("get_reset_pulse", 32'(get_pulse), 0);
        reset = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            selected_group = 3'($urandom_range(7));
            step(($urandom_range(9) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                 ($urandom_range(1) == 0) ? selected_group : 3'($urandom_range(7)),
                 ($urandom_range(11) == 0));
        end
        reset = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TIME_INIT, default 6'd60: round length in sec_tick units.
REQ-002 Parameter LIVES_INIT, default 2'd3: balls per game.
REQ-003 Parameter GET_HOLD, default 3'd2: sec_tick count spent in GET per match.
REQ-004 Parameter MATCH_PTS, default 8'd2: points for a hit in the selected group.
REQ-005 Parameter HIT_PTS, default 8'd1: points for a hit in any other group.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 btn_start  input  1  one-cycle pulse, debounced start/restart button.
REQ-009 sec_tick  input  1  one-cycle enable pulse, nominally 1 Hz.
REQ-010 hit  input  1  one-cycle pulse: ball struck a target group.
REQ-011 hit_group  input  3  group index struck; valid only when hit=1.
REQ-012 miss  input  1  one-cycle pulse: ball drained.
REQ-013 selected_group  input  3  currently selected target group, from the group selector.
REQ-014 state  output  3  registered game state: RESET=0, WAIT=1, START=2, GET=3, OVER=4.
REQ-015 score  output  8  registered score, unsigned.
REQ-016 lives  output  2  registered remaining balls.
REQ-017 time_left  output  6  registered remaining round time.
REQ-018 get_pulse  output  1  registered one-cycle pulse on every entry to GET.

Function
REQ-019 Every output SHALL update on the clock edge after the causing input; latency SHALL be 1 cycle.
REQ-020 RESET SHALL load score=0, lives=LIVES_INIT, time_left=TIME_INIT, hold counter=0, and go to WAIT on the next cycle unconditionally.
REQ-021 WAIT SHALL hold score, lives and time_left; btn_start SHALL move to START; hit, miss and sec_tick SHALL be ignored.
REQ-022 In START and GET, sec_tick SHALL decrement time_left by 1; sec_tick with time_left=1 SHALL set time_left=0 and move to OVER.
REQ-023 In START, hit with hit_group==selected_group SHALL add MATCH_PTS, move to GET and pulse get_pulse.
REQ-024 In START, hit with hit_group!=selected_group SHALL add HIT_PTS and stay in START.
REQ-025 Score addition SHALL saturate at 8'd255; it SHALL never wrap.
REQ-026 In START and GET, miss SHALL decrement lives; miss with lives=1 SHALL set lives=0 and move to OVER.
REQ-027 In GET, hit SHALL be ignored; each sec_tick SHALL increment the hold counter; at GET_HOLD ticks SHALL clear the counter and return to START.
REQ-028 Simultaneous events in one cycle SHALL be resolved by priority: OVER conditions (time expiry, last life lost) first, then miss, then hit; if miss and hit coincide, SHALL apply the miss only and drop the hit.
REQ-029 If sec_tick and a non-terminal miss coincide, SHALL apply both (time_left-1, lives-1).
REQ-030 If time expiry and GET hold completion coincide, SHALL go to OVER.
REQ-031 OVER SHALL freeze score, lives and time_left; btn_start SHALL move to RESET; all other inputs SHALL be ignored.
REQ-032 btn_start in START or GET SHALL be ignored.
REQ-033 Undefined state encodings (5-7) SHALL move to RESET on the next cycle.
REQ-034 get_pulse SHALL be 0 in every cycle except the first cycle in GET.

Reset
REQ-035 reset=1 SHALL, on the next edge and from any state (including mid-GET), force state=RESET, score=0, lives=LIVES_INIT, time_left=TIME_INIT, get_pulse=0 and hold counter=0.
REQ-036 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-037 Reset, then btn_start -> RESET, WAIT, START; score=0, lives=3, time_left=60.
REQ-038 In START, selected_group=5, hit with hit_group=5 -> score=2, state=GET, get_pulse high 1 cycle; after 2 sec_ticks -> START.
REQ-039 In START, hit with hit_group=1 while selected_group=5 -> score+1, state stays START; score=254 plus a match hit -> 255.
REQ-040 Three misses in START -> lives 2, 1, 0; OVER on the third; btn_start -> RESET, then WAIT.
REQ-041 time_left=1, sec_tick and a matching hit in the same cycle -> OVER, time_left=0, score unchanged.
REQ-042 reset asserted in GET with hold counter=1 -> RESET next cycle, all outputs at reset values.
